// File: rtl/alt_vipswi131_common_pixel_position_counter.sv
`default_nettype none
// ============================================================================
// Module  : alt_vipswi131_common_pixel_position_counter
// Purpose : Counts valid beats into plane ticks, pixels and lines, and flags
//           sample, line and frame boundaries with zero latency.
// Revision: 1.0 - initial release
// ============================================================================
module alt_vipswi131_common_pixel_position_counter #(
    parameter int MAX_PLANES_IN_SEQ = 3,
    parameter int LOG2_MAX_PLANES   = 2,
    parameter int WIDTH_BITS        = 12,
    parameter int HEIGHT_BITS       = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclr,
    input  logic                       count_cycle,
    input  logic                       hd_sdn,
    input  logic [LOG2_MAX_PLANES-1:0] cfg_planes_m1,
    input  logic [WIDTH_BITS-1:0]      cfg_width_m1,
    input  logic [HEIGHT_BITS-1:0]     cfg_height_m1,
    input  logic                       cfg_load,
    output logic                       count_sample,
    output logic                       start_of_sample,
    output logic [LOG2_MAX_PLANES-1:0] sample_ticks,
    output logic [WIDTH_BITS-1:0]      pixel_x,
    output logic [HEIGHT_BITS-1:0]     pixel_y,
    output logic                       end_of_line,
    output logic                       end_of_frame,
    output logic                       frame_active,
    output logic                       cfg_pending
);

    localparam logic [LOG2_MAX_PLANES-1:0] MAX_PLANES_M1 = LOG2_MAX_PLANES'(MAX_PLANES_IN_SEQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                     r_state;
    logic [LOG2_MAX_PLANES-1:0] r_ticks;
    logic [LOG2_MAX_PLANES-1:0] w_ticks_next;
    logic [WIDTH_BITS-1:0]      r_x;
    logic [HEIGHT_BITS-1:0]     r_y;
    logic [LOG2_MAX_PLANES-1:0] r_planes_m1;
    logic [WIDTH_BITS-1:0]      r_width_m1;
    logic [HEIGHT_BITS-1:0]     r_height_m1;
    logic [LOG2_MAX_PLANES-1:0] r_shadow_planes_m1;
    logic [WIDTH_BITS-1:0]      r_shadow_width_m1;
    logic [HEIGHT_BITS-1:0]     r_shadow_height_m1;
    logic                       r_pending;

    logic                       w_last_plane;
    logic                       w_count_sample;
    logic                       w_end_of_line;
    logic                       w_end_of_frame;
    logic [LOG2_MAX_PLANES-1:0] w_cfg_planes_clamped;
    logic [LOG2_MAX_PLANES-1:0] w_next_planes_m1;
    logic [WIDTH_BITS-1:0]      w_next_width_m1;
    logic [HEIGHT_BITS-1:0]     w_next_height_m1;
    logic                       w_sclr_complete;
    logic                       w_sclr_single;

    always_comb begin
        w_last_plane   = hd_sdn | (r_ticks == r_planes_m1);
        w_count_sample = count_cycle & w_last_plane;
        w_end_of_line  = w_count_sample & (r_x == r_width_m1);
        w_end_of_frame = w_end_of_line & (r_y == r_height_m1);
    end

    // Config that a restart would run with: fresh load beats shadow beats active.
    always_comb begin
        w_cfg_planes_clamped = (cfg_planes_m1 > MAX_PLANES_M1) ? MAX_PLANES_M1 : cfg_planes_m1;
        if (cfg_load) begin
            w_next_planes_m1 = w_cfg_planes_clamped;
            w_next_width_m1  = cfg_width_m1;
            w_next_height_m1 = cfg_height_m1;
        end else if (r_pending) begin
            w_next_planes_m1 = r_shadow_planes_m1;
            w_next_width_m1  = r_shadow_width_m1;
            w_next_height_m1 = r_shadow_height_m1;
        end else begin
            w_next_planes_m1 = r_planes_m1;
            w_next_width_m1  = r_width_m1;
            w_next_height_m1 = r_height_m1;
        end
        w_sclr_complete = count_cycle & (hd_sdn | (w_next_planes_m1 == '0));
        w_sclr_single   = w_sclr_complete & (w_next_width_m1 == '0) & (w_next_height_m1 == '0);
    end

    always_comb begin
        w_ticks_next = r_ticks;
        if (sclr) begin
            w_ticks_next = (count_cycle & ~hd_sdn & (w_next_planes_m1 != '0))
                           ? LOG2_MAX_PLANES'(1) : '0;
        end else if (hd_sdn | w_count_sample) begin
            w_ticks_next = '0;
        end else if (count_cycle) begin
            w_ticks_next = r_ticks + LOG2_MAX_PLANES'(1);
        end
    end

    generate
        if (MAX_PLANES_IN_SEQ == 1) begin : g_ticks_tied
            assign r_ticks = '0;
        end else begin : g_ticks_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ticks <= '0;
                end else begin
                    r_ticks <= w_ticks_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_x                <= '0;
            r_y                <= '0;
            r_planes_m1        <= '0;
            r_width_m1         <= '0;
            r_height_m1        <= '0;
            r_shadow_planes_m1 <= '0;
            r_shadow_width_m1  <= '0;
            r_shadow_height_m1 <= '0;
            r_pending          <= 1'b0;
        end else if (sclr) begin
            r_planes_m1 <= w_next_planes_m1;
            r_width_m1  <= w_next_width_m1;
            r_height_m1 <= w_next_height_m1;
            r_pending   <= 1'b0;
            r_x         <= (w_sclr_complete && (w_next_width_m1 != '0)) ? WIDTH_BITS'(1) : '0;
            r_y         <= (w_sclr_complete && (w_next_width_m1 == '0) && (w_next_height_m1 != '0))
                           ? HEIGHT_BITS'(1) : '0;
            r_state     <= (count_cycle && !w_sclr_single) ? ST_ACTIVE : ST_IDLE;
        end else begin
            if (w_count_sample) begin
                r_x <= w_end_of_line ? '0 : r_x + WIDTH_BITS'(1);
            end
            if (w_end_of_line) begin
                r_y <= w_end_of_frame ? '0 : r_y + HEIGHT_BITS'(1);
            end

            case (r_state)
                ST_IDLE:   if (count_cycle && !w_end_of_frame) r_state <= ST_ACTIVE;
                ST_ACTIVE: if (w_end_of_frame) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase

            // Active config only moves while no frame is in flight or at its last beat.
            if (cfg_load) begin
                if ((r_state == ST_IDLE && !count_cycle) || w_end_of_frame) begin
                    r_planes_m1 <= w_cfg_planes_clamped;
                    r_width_m1  <= cfg_width_m1;
                    r_height_m1 <= cfg_height_m1;
                    r_pending   <= 1'b0;
                end else begin
                    r_shadow_planes_m1 <= w_cfg_planes_clamped;
                    r_shadow_width_m1  <= cfg_width_m1;
                    r_shadow_height_m1 <= cfg_height_m1;
                    r_pending          <= 1'b1;
                end
            end else if (w_end_of_frame && r_pending) begin
                r_planes_m1 <= r_shadow_planes_m1;
                r_width_m1  <= r_shadow_width_m1;
                r_height_m1 <= r_shadow_height_m1;
                r_pending   <= 1'b0;
            end
        end
    end

    assign count_sample    = w_count_sample;
    assign start_of_sample = hd_sdn | (r_ticks == '0);
    assign sample_ticks    = r_ticks;
    assign pixel_x         = r_x;
    assign pixel_y         = r_y;
    assign end_of_line     = w_end_of_line;
    assign end_of_frame    = w_end_of_frame;
    assign frame_active    = (r_state == ST_ACTIVE);
    assign cfg_pending     = r_pending;

endmodule
`default_nettype wire
